warp_issue_scoreboard: RTL

- Parametrised successor to the combinational warp readiness check. It folds the per-thread busy scoreboard into the block and adds a registered readiness vector and a round-robin issue arbiter with a valid/ready handshake.
- Sits between the instruction buffer (per-warp next-instruction masks) and the execution lanes (issue and completion).
- Busy state is set on issue and cleared on completion, so the block tracks thread occupancy itself.

---
 rtl/warp_issue_scoreboard.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/warp_issue_scoreboard.sv
// warp_issue_scoreboard
//   Tracks per-thread occupancy of every warp, registers a per-warp readiness
//   vector and issues one warp at a time through a round-robin arbiter with a
//   valid/ready handshake.
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     instr_valid/mask   per-warp pending instruction from the instruction buffer
//     instr_pop          one-hot pop pulse to the buffer, asserted in the fire cycle
//     issue_valid/ready  issue handshake towards the execution lanes
//     issue_warp/mask    offered warp and its thread-group mask (held while valid)
//     cmpl_valid/warp/mask  completion event that frees thread groups
//     ready_warps        registered readiness vector (1-cycle latency)
//     busy_threads       scoreboard, warp w at [w*THREADS_PER_WARP +: THREADS_PER_WARP]
//     err_spurious       sticky: completion of a non-busy thread or a bad warp id

// Per-warp readiness: pending instruction whose decoded threads are all idle.
module wis_lane #(
   parameter int TPW = 8,
   parameter int GS  = 2,
   parameter int MW  = TPW/GS
) (
   input  logic           valid,
   input  logic [MW-1:0]  mask,
   input  logic [TPW-1:0] busy,
   output logic           rdy
);
   logic [TPW-1:0] dec;

   always_comb begin
      dec = '0;
      for (int k = 0; k < MW; k++) dec[k*GS +: GS] = {GS{mask[k]}};
   end

   assign rdy = valid && ((dec & busy) == '0);
endmodule

module warp_issue_scoreboard #(
   parameter  int NUM_WARPS        = 4,
   parameter  int THREADS_PER_WARP = 8,
   parameter  int GROUP_SIZE       = 2,
   localparam int MASK_W           = THREADS_PER_WARP/GROUP_SIZE,
   localparam int WID_W            = $clog2(NUM_WARPS)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_WARPS-1:0]                 instr_valid,
   input  logic [NUM_WARPS-1:0][MASK_W-1:0]     instr_mask,
   output logic [NUM_WARPS-1:0]                 instr_pop,
   output logic                                 issue_valid,
   input  logic                                 issue_ready,
   output logic [WID_W-1:0]                     issue_warp,
   output logic [MASK_W-1:0]                    issue_mask,
   input  logic                                 cmpl_valid,
   input  logic [WID_W-1:0]                     cmpl_warp,
   input  logic [MASK_W-1:0]                    cmpl_mask,
   output logic [NUM_WARPS-1:0]                 ready_warps,
   output logic [NUM_WARPS*THREADS_PER_WARP-1:0] busy_threads,
   output logic                                 err_spurious
);
   localparam int TPW = THREADS_PER_WARP;

   typedef enum logic {IDLE, OFFER} state_t;

   state_t                        state_q, state_d;
   logic [WID_W-1:0]              rr_q, rr_d, ptr_inc, wsel;
   logic [NUM_WARPS-1:0][TPW-1:0] busy_q, busy_d, set_v, clr_v;
   logic [NUM_WARPS-1:0]          rdy_c, rdy_x, own;
   logic                          fire, load, spur, cw_ok;

   function automatic logic [TPW-1:0] decode(input logic [MASK_W-1:0] m);
      logic [TPW-1:0] d;
      d = '0;
      for (int k = 0; k < MASK_W; k++) d[k*GROUP_SIZE +: GROUP_SIZE] = {GROUP_SIZE{m[k]}};
      return d;
   endfunction

   // First requester at or after ptr (wrapping). Scanning downwards lets the
   // nearest candidate overwrite farther ones, so no "found" flag is needed.
   function automatic logic [WID_W-1:0] rr_pick(input logic [NUM_WARPS-1:0] req,
                                                input logic [WID_W-1:0]     ptr);
      logic [WID_W-1:0] w;
      int               idx;
      w = '0;
      for (int i = NUM_WARPS-1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_WARPS;
         if (req[idx]) w = WID_W'(idx);
      end
      return w;
   endfunction

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_lane
      wis_lane #(.TPW(TPW), .GS(GROUP_SIZE), .MW(MASK_W)) u_lane (
         .valid (instr_valid[w]),
         .mask  (instr_mask[w]),
         .busy  (busy_q[w]),
         .rdy   (rdy_c[w])
      );
   end

   assign issue_valid  = (state_q == OFFER);
   assign fire         = issue_valid && issue_ready;
   assign own          = NUM_WARPS'(1) << issue_warp;
   assign instr_pop    = fire ? own : '0;
   assign ptr_inc      = (issue_warp == WID_W'(NUM_WARPS-1)) ? '0 : issue_warp + 1'b1;
   assign busy_threads = busy_q;

   // Arbiter / offer FSM. After a fire the fired warp is masked out because its
   // buffer entry is being popped this very edge.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      wsel    = issue_warp;
      load    = 1'b0;
      rdy_x   = rdy_c;
      case (state_q)
         IDLE: if (|rdy_c) begin
            load    = 1'b1;
            wsel    = rr_pick(rdy_c, rr_q);
            state_d = OFFER;
         end
         OFFER: if (fire) begin
            rr_d  = ptr_inc;
            rdy_x = rdy_c & ~own;
            if (|rdy_x) begin
               load = 1'b1;
               wsel = rr_pick(rdy_x, ptr_inc);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scoreboard update: clear on completion, set on fire; set wins on overlap.
   always_comb begin
      set_v = '0;
      clr_v = '0;
      spur  = 1'b0;
      cw_ok = 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) if (cmpl_warp == WID_W'(w)) cw_ok = 1'b1;
      if (fire) set_v[issue_warp] = decode(issue_mask);
      if (cmpl_valid) begin
         if (cw_ok) begin
            clr_v[cmpl_warp] = decode(cmpl_mask);
            spur = |(clr_v[cmpl_warp] & ~busy_q[cmpl_warp]);
         end else begin
            spur = 1'b1;
         end
      end
      busy_d = (busy_q & ~clr_v) | set_v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         issue_warp   <= '0;
         issue_mask   <= '0;
         busy_q       <= '0;
         ready_warps  <= '0;
         err_spurious <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         busy_q      <= busy_d;
         ready_warps <= rdy_c;
         if (spur) err_spurious <= 1'b1;
         if (load) begin
            issue_warp <= wsel;
            issue_mask <= instr_mask[wsel];
         end
      end
   end
endmodule
